// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// Holds default geometry and the drop counter width.
package demux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_CH  = 4;
    localparam int DROP_W    = 8;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel holding register: load, drain, or hold a single word.
// Data is cleared whenever the slot is empty so the output reads zero.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    // Free when empty or when the current word leaves this cycle.
    assign free = ~valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
            data  <= '0;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Stream demultiplexer: routes one input word to a selected channel, or to all
// channels at once, with one holding register per channel.
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*WIDTH-1:0] out_data,
    output logic                  err_sel,
    output logic [DROP_W-1:0]     drop_cnt
);

    // Handshake: a word moves on any port in a cycle where valid and ready are
    // both 1. in_ready never looks at in_valid; out_valid never looks at out_ready.
    localparam logic [SEL_W:0] N_CH_EXT = (SEL_W+1)'(N_CH);

    logic [N_CH-1:0] free;
    logic [N_CH-1:0] load;
    logic            oob;
    logic            sel_free;
    logic            accept;

    assign oob = ~in_bcast & ({1'b0, in_sel} >= N_CH_EXT);

    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (in_sel == SEL_W'(k)) sel_free = free[k];
        end
    end

    // Broadcast waits for every slot so a word is never partially delivered.
    assign in_ready = in_bcast ? (&free) : (oob ? 1'b1 : sel_free);
    assign accept   = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = accept & ~oob & (in_bcast | (in_sel == SEL_W'(k)));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[g]),
            .load_data (in_data),
            .ready     (out_ready[g]),
            .valid     (out_valid[g]),
            .data      (out_data[g*WIDTH +: WIDTH]),
            .free      (free[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_sel <= accept & oob;
            if (accept && oob) drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule
